// File: rtl/mnist_argmax.sv
// mnist_argmax
//   Receives the final-layer logit vector (one beat per image), scans it one
//   channel per cycle for the largest signed logit and presents the winning
//   class index on a valid/ready handshake.
//
// Ports
//   clk, rst, ce            clock, synchronous active-high reset, clock enable
//   conv_din                NUM_CLASS logits, channel c at [c*N +: N]
//   conv_din_vld/_end       beat valid / last beat of image
//   class_dout, class_vld   winning class index and its valid (held until taken)
//   class_rdy               consumer ready
//   busy                    FSM not IDLE
//   overrun                 sticky: a beat was dropped because the block was busy
//   class_score             winning logit (only with MNIST_ARGMAX_SCORE_EN)
//
// Configuration macro: MNIST_ARGMAX_SCORE_EN adds the class_score output.
//
// state | meaning
// IDLE  | waiting for a beat; non-final beats overwrite the logit register
// SCAN  | comparing channel idx against the running best, one per cycle
// DONE  | result presented, waiting for class_rdy
module mnist_argmax #(
  parameter int N         = 8,
  parameter int NUM_CLASS = 10,
  parameter int CLASS_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [NUM_CLASS*N-1:0] conv_din,
  input  logic                   conv_din_vld,
  input  logic                   conv_din_end,
  output logic [CLASS_W-1:0]     class_dout,
  output logic                   class_vld,
  input  logic                   class_rdy,
  output logic                   busy,
  output logic                   overrun
`ifdef MNIST_ARGMAX_SCORE_EN
  ,
  output logic [N-1:0]           class_score
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASS - 1);

  state_e                 state_q, state_d;
  logic [NUM_CLASS*N-1:0] logit_q, logit_d;
  logic [N-1:0]           best_q, best_d;
  logic [CLASS_W-1:0]     best_idx_q, best_idx_d;
  logic [CLASS_W-1:0]     idx_q, idx_d;
  logic [CLASS_W-1:0]     class_dout_q, class_dout_d;
  logic                   class_vld_q, class_vld_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic [N-1:0]           ch_sel;
  logic                   take;
`ifdef MNIST_ARGMAX_SCORE_EN
  logic [N-1:0]           score_q, score_d;
`endif

  always_comb begin
    ch_sel = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (idx_q == CLASS_W'(c)) ch_sel = logit_q[c*N +: N];
    end
  end

  always_comb begin
    state_d      = state_q;
    logit_d      = logit_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    idx_d        = idx_q;
    class_dout_d = class_dout_q;
    class_vld_d  = class_vld_q;
    overrun_d    = overrun_q;
`ifdef MNIST_ARGMAX_SCORE_EN
    score_d      = score_q;
`endif
    // A beat is accepted in IDLE, or in DONE on the same edge the result is taken.
    take = conv_din_vld && (state_q == IDLE || (state_q == DONE && class_rdy));

    case (state_q)
      SCAN: begin
        // Strict compare keeps the lowest index on ties.
        if ($signed(ch_sel) > $signed(best_q)) begin
          best_d     = ch_sel;
          best_idx_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d      = DONE;
          class_dout_d = best_idx_d;
          class_vld_d  = 1'b1;
`ifdef MNIST_ARGMAX_SCORE_EN
          score_d      = best_d;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (class_rdy) begin
          class_vld_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    if (take) begin
      logit_d    = conv_din;
      best_d     = conv_din[N-1:0];
      best_idx_d = '0;
      idx_d      = (NUM_CLASS > 1) ? CLASS_W'(1) : '0;
      if (conv_din_end) begin
        if (NUM_CLASS == 1) begin
          state_d      = DONE;
          class_dout_d = '0;
          class_vld_d  = 1'b1;
`ifdef MNIST_ARGMAX_SCORE_EN
          score_d      = conv_din[N-1:0];
`endif
        end else begin
          state_d = SCAN;
        end
      end
    end else if (conv_din_vld && state_q != IDLE) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      logit_q      <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      idx_q        <= '0;
      class_dout_q <= '0;
      class_vld_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef MNIST_ARGMAX_SCORE_EN
      score_q      <= '0;
`endif
    end else if (ce) begin
      state_q      <= state_d;
      logit_q      <= logit_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      idx_q        <= idx_d;
      class_dout_q <= class_dout_d;
      class_vld_q  <= class_vld_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
`ifdef MNIST_ARGMAX_SCORE_EN
      score_q      <= score_d;
`endif
    end
  end

  assign class_dout = class_dout_q;
  assign class_vld  = class_vld_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
`ifdef MNIST_ARGMAX_SCORE_EN
  assign class_score = score_q;
`endif

endmodule

// File: tb/tb_mnist_argmax.sv
module tb_mnist_argmax;

  localparam int N = 8;
  localparam int NC = 10;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ce = 1'b1;
  logic [NC*N-1:0] conv_din = '0;
  logic            conv_din_vld = 1'b0;
  logic            conv_din_end = 1'b0;
  logic [CW-1:0]   class_dout;
  logic            class_vld;
  logic            class_rdy = 1'b0;
  logic            busy;
  logic            overrun;
`ifdef MNIST_ARGMAX_SCORE_EN
  logic [N-1:0]    class_score;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [CW-1:0] cls;
    logic [N-1:0]  score;
  } exp_t;
  exp_t sb[$];

  mnist_argmax #(.N(N), .NUM_CLASS(NC), .CLASS_W(CW)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .conv_din(conv_din), .conv_din_vld(conv_din_vld), .conv_din_end(conv_din_end),
    .class_dout(class_dout), .class_vld(class_vld), .class_rdy(class_rdy),
    .busy(busy), .overrun(overrun)
`ifdef MNIST_ARGMAX_SCORE_EN
    , .class_score(class_score)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a transfer happens on the next edge when vld & rdy & ce.
  always @(negedge clk) begin
    if (!rst && class_vld && class_rdy && ce) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("class_dout", int'(class_dout), int'(e.cls));
`ifdef MNIST_ARGMAX_SCORE_EN
        check("class_score", int'(class_score), int'(e.score));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*N-1:0] vec(input logic [7:0] def);
    logic [NC*N-1:0] v;
    for (int c = 0; c < NC; c++) v[c*N +: N] = def;
    return v;
  endfunction

  // Drive one beat for a single enabled edge.
  task automatic beat(input logic [NC*N-1:0] v, input logic last);
    conv_din     = v;
    conv_din_vld = 1'b1;
    conv_din_end = last;
    tick();
    conv_din_vld = 1'b0;
    conv_din_end = 1'b0;
  endtask

  task automatic push(input int cls, input logic [7:0] score);
    exp_t e;
    e.cls   = CW'(cls);
    e.score = score;
    sb.push_back(e);
  endtask

  // Counts edges from now until class_vld is seen; bounded.
  task automatic wait_vld(output int n);
    n = 0;
    while (!class_vld && n < 40) begin
      tick();
      n++;
    end
    if (!class_vld) check("wait_vld_timeout", 0, 1);
  endtask

  task automatic accept();
    class_rdy = 1'b1;
    tick();
    class_rdy = 1'b0;
  endtask

  initial begin
    logic [NC*N-1:0] v;
    int n;
    int seen;

    repeat (3) tick();
    rst = 1'b0;
    check("rst_vld", int'(class_vld), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_dout", int'(class_dout), 0);

    // 1: single peak at channel 7
    v = vec(8'h00); v[7*N +: N] = 8'h40;
    push(7, 8'h40);
    beat(v, 1'b1);
    check("t1_busy", int'(busy), 1);
    wait_vld(n);
    check("t1_latency", n, 9);
    repeat (3) tick();
    check("t1_hold_vld", int'(class_vld), 1);
    check("t1_hold_dout", int'(class_dout), 7);
    accept();
    check("t1_vld_drop", int'(class_vld), 0);
    check("t1_busy_after", int'(busy), 0);

    // 2: tie resolves to lowest index
    v = vec(8'h10); v[2*N +: N] = 8'h7F; v[5*N +: N] = 8'h7F;
    push(2, 8'h7F);
    beat(v, 1'b1);
    wait_vld(n);
    check("t2_latency", n, 9);
    accept();

    // 3: signed compare
    v = vec(8'h9C); v[0 +: N] = 8'h80; v[3*N +: N] = 8'hFF;
    push(3, 8'hFF);
    beat(v, 1'b1);
    wait_vld(n);
    accept();
    check("t3_overrun", int'(overrun), 0);

    // 4a: new beat on the accept edge is captured without overrun
    v = vec(8'h00); v[6*N +: N] = 8'h30;
    push(6, 8'h30);
    beat(v, 1'b1);
    wait_vld(n);
    v = vec(8'h00); v[1*N +: N] = 8'h50;
    push(1, 8'h50);
    class_rdy = 1'b1;
    beat(v, 1'b1);
    class_rdy = 1'b0;
    check("t4a_overrun", int'(overrun), 0);
    check("t4a_busy", int'(busy), 1);
    check("t4a_vld", int'(class_vld), 0);
    wait_vld(n);
    check("t4a_latency", n, 9);

    // 4b: beat while result held is dropped
    repeat (5) tick();
    v = vec(8'h00); v[5*N +: N] = 8'h50;
    beat(v, 1'b1);
    check("t4b_overrun", int'(overrun), 1);
    check("t4b_dout", int'(class_dout), 1);
    repeat (14) tick();
    check("t4b_vld", int'(class_vld), 1);
    check("t4b_overrun_sticky", int'(overrun), 1);
    accept();

    // 5: reset in the middle of a scan
    v = vec(8'h00); v[8*N +: N] = 8'h11;
    beat(v, 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", int'(busy), 0);
    check("t5_overrun_clr", int'(overrun), 0);
    seen = 0;
    repeat (15) begin
      tick();
      if (class_vld) seen = 1;
    end
    check("t5_no_vld", seen, 0);
    v = vec(8'h00); v[9*N +: N] = 8'h01;
    push(9, 8'h01);
    beat(v, 1'b1);
    wait_vld(n);
    check("t5_latency", n, 9);
    accept();

    // 6: non-final beat overwritten; ce stall mid-scan
    v = vec(8'h00); v[0 +: N] = 8'h70;
    beat(v, 1'b0);
    check("t6_idle_busy", int'(busy), 0);
    v = vec(8'h00); v[4*N +: N] = 8'h20;
    push(4, 8'h20);
    beat(v, 1'b1);
    tick(); tick();
    ce = 1'b0;
    repeat (3) tick();
    check("t6_stall_busy", int'(busy), 1);
    check("t6_stall_vld", int'(class_vld), 0);
    ce = 1'b1;
    wait_vld(n);
    check("t6_latency", n + 5, 12);
    accept();

    tick();
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
